// File: rtl/jac_pkg.sv
// Shared definitions for the Jac1-8 core: widths, opcodes, and the fetch state encoding.
package jac_pkg;

    localparam int PC_WIDTH          = 8;
    localparam int PROGRAM_DataWidth = 16;
    localparam int NumOpCodeBits     = 4;

    localparam logic [NumOpCodeBits-1:0] Op_NOP   = 4'd0;
    localparam logic [NumOpCodeBits-1:0] Op_LOAD  = 4'd1;
    localparam logic [NumOpCodeBits-1:0] Op_STORE = 4'd2;
    localparam logic [NumOpCodeBits-1:0] Op_ADD   = 4'd3;
    localparam logic [NumOpCodeBits-1:0] Op_SUB   = 4'd4;
    localparam logic [NumOpCodeBits-1:0] Op_AND   = 4'd5;
    localparam logic [NumOpCodeBits-1:0] Op_OR    = 4'd6;
    localparam logic [NumOpCodeBits-1:0] Op_XOR   = 4'd7;
    localparam logic [NumOpCodeBits-1:0] Op_JMP   = 4'd8;
    localparam logic [NumOpCodeBits-1:0] Op_IFEQ  = 4'd9;
    localparam logic [NumOpCodeBits-1:0] Op_IFGT  = 4'd10;

    localparam logic [15:0] INSTR_NOP = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// Program counter: load a jump target, increment with natural wrap, or hold.
module program_counter #(
    parameter int WIDTH = jac_pkg::PC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_pc
);
    import jac_pkg::*;

    logic [WIDTH-1:0] r_pc;

    // Load wins over increment; the add wraps modulo 2^WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= r_pc + WIDTH'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Jac1-8 fetch stage: fetches one instruction word per request and presents it
// to the decoder for a single EXEC cycle, then advances or jumps the PC.
//
// state    | meaning
// ST_IDLE  | parked, no request; leaves when run=1
// ST_FETCH | mem_req held with mem_addr=pc until mem_ack
// ST_EXEC  | IR presented to decoder; pc updated at cycle end
module fetch_unit #(
    parameter int PC_WIDTH          = jac_pkg::PC_WIDTH,
    parameter int PROGRAM_DataWidth = jac_pkg::PROGRAM_DataWidth
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         run,
    output logic                         mem_req,
    output logic [PC_WIDTH-1:0]          mem_addr,
    input  logic                         mem_ack,
    input  logic [PROGRAM_DataWidth-1:0] mem_rdata,
    output logic [PROGRAM_DataWidth-1:0] instruction,
    output logic                         instr_valid,
    input  logic                         cnt_wr_en,
    input  logic [PC_WIDTH-1:0]          literal_adr,
    output logic [PC_WIDTH-1:0]          pc
);
    import jac_pkg::*;

    fetch_state_t                 r_state;
    fetch_state_t                 w_state_nxt;
    logic [PROGRAM_DataWidth-1:0] r_ir;
    logic                         w_ir_load;
    logic                         w_pc_load;
    logic                         w_pc_inc;
    logic [PC_WIDTH-1:0]          w_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs decode from state only, so reset drops mem_req immediately.
    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        instr_valid = 1'b0;
        instruction = PROGRAM_DataWidth'(INSTR_NOP);
        w_ir_load   = 1'b0;
        w_pc_load   = 1'b0;
        w_pc_inc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    w_ir_load   = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                instr_valid = 1'b1;
                instruction = r_ir;
                w_pc_load   = cnt_wr_en;
                w_pc_inc    = ~cnt_wr_en;
                w_state_nxt = run ? ST_FETCH : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir <= '0;
        end else if (w_ir_load) begin
            r_ir <= mem_rdata;
        end
    end

    program_counter #(
        .WIDTH(PC_WIDTH)
    ) u_program_counter (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_pc_load),
        .i_inc     (w_pc_inc),
        .i_load_val(literal_adr),
        .o_pc      (w_pc)
    );

    assign mem_addr = w_pc;
    assign pc       = w_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector table plus reset corner sequences.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        run;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        cnt_wr_en;
    logic [7:0]  literal_adr;
    logic [7:0]  pc;
    logic        junk;

    int n_cmp;
    int n_fail;

    fetch_unit #(
        .PC_WIDTH         (8),
        .PROGRAM_DataWidth(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .cnt_wr_en  (cnt_wr_en),
        .literal_adr(literal_adr),
        .pc         (pc)
    );

    // Memory model: word = 16'h0800 | addr, or a junk pattern for stray-ack stimulus.
    assign mem_rdata = junk ? 16'hBEEF : (16'h0800 | {8'h00, mem_addr});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic        ack;
        logic        junk;
        logic        cnt;
        logic [7:0]  lit;
        logic        req;
        logic [7:0]  addr;
        logic        valid;
        logic [15:0] instr;
        logic [7:0]  pc;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(input logic r, input logic a, input logic j, input logic c,
                                input logic [7:0] l, input logic q, input logic [7:0] ad,
                                input logic v, input logic [15:0] ins, input logic [7:0] p);
        vec_t t;
        t.run = r; t.ack = a; t.junk = j; t.cnt = c; t.lit = l;
        t.req = q; t.addr = ad; t.valid = v; t.instr = ins; t.pc = p;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst = 1'b1; run = 1'b0; mem_ack = 1'b0; junk = 1'b0;
        cnt_wr_en = 1'b0; literal_adr = 8'h00;

        //          run ack jnk cnt lit    req addr  vld instr     pc
        vecs[0]  = mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 8'h00);
        vecs[1]  = mk(1, 1, 0, 0, 8'h00, 1, 8'h00, 0, 16'h0000, 8'h00);
        vecs[2]  = mk(1, 1, 1, 0, 8'h00, 0, 8'h00, 1, 16'h0800, 8'h00);
        vecs[3]  = mk(1, 1, 0, 0, 8'h00, 1, 8'h01, 0, 16'h0000, 8'h01);
        vecs[4]  = mk(1, 0, 0, 0, 8'h00, 0, 8'h01, 1, 16'h0801, 8'h01);
        vecs[5]  = mk(1, 0, 0, 0, 8'h00, 1, 8'h02, 0, 16'h0000, 8'h02);
        vecs[6]  = mk(1, 0, 0, 0, 8'h00, 1, 8'h02, 0, 16'h0000, 8'h02);
        vecs[7]  = mk(1, 0, 0, 0, 8'h00, 1, 8'h02, 0, 16'h0000, 8'h02);
        vecs[8]  = mk(1, 1, 0, 0, 8'h00, 1, 8'h02, 0, 16'h0000, 8'h02);
        vecs[9]  = mk(1, 0, 0, 0, 8'h00, 0, 8'h02, 1, 16'h0802, 8'h02);
        vecs[10] = mk(1, 1, 0, 0, 8'h00, 1, 8'h03, 0, 16'h0000, 8'h03);
        vecs[11] = mk(1, 0, 0, 0, 8'h00, 0, 8'h03, 1, 16'h0803, 8'h03);
        vecs[12] = mk(1, 1, 0, 0, 8'h00, 1, 8'h04, 0, 16'h0000, 8'h04);
        vecs[13] = mk(1, 0, 0, 0, 8'h00, 0, 8'h04, 1, 16'h0804, 8'h04);
        vecs[14] = mk(1, 1, 0, 0, 8'h00, 1, 8'h05, 0, 16'h0000, 8'h05);
        vecs[15] = mk(1, 0, 0, 1, 8'h3F, 0, 8'h05, 1, 16'h0805, 8'h05);
        vecs[16] = mk(1, 1, 0, 1, 8'h77, 1, 8'h3F, 0, 16'h0000, 8'h3F);
        vecs[17] = mk(1, 0, 0, 0, 8'h00, 0, 8'h3F, 1, 16'h083F, 8'h3F);
        vecs[18] = mk(1, 1, 0, 0, 8'h00, 1, 8'h40, 0, 16'h0000, 8'h40);
        vecs[19] = mk(1, 0, 0, 1, 8'hFF, 0, 8'h40, 1, 16'h0840, 8'h40);
        vecs[20] = mk(1, 1, 0, 0, 8'h00, 1, 8'hFF, 0, 16'h0000, 8'hFF);
        vecs[21] = mk(1, 0, 0, 0, 8'h00, 0, 8'hFF, 1, 16'h08FF, 8'hFF);
        vecs[22] = mk(0, 0, 0, 0, 8'h00, 1, 8'h00, 0, 16'h0000, 8'h00);
        vecs[23] = mk(0, 1, 0, 0, 8'h00, 1, 8'h00, 0, 16'h0000, 8'h00);
        vecs[24] = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 1, 16'h0800, 8'h00);
        vecs[25] = mk(0, 1, 1, 0, 8'h00, 0, 8'h01, 0, 16'h0000, 8'h01);
        vecs[26] = mk(0, 0, 0, 0, 8'h00, 0, 8'h01, 0, 16'h0000, 8'h01);

        // Reset with run low: everything zero, then no request for 5 cycles.
        #2;
        chk("rst_req",   32'(mem_req),     32'h0);
        chk("rst_addr",  32'(mem_addr),    32'h0);
        chk("rst_instr", 32'(instruction), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_pc",    32'(pc),          32'h0);
        chk("rst_ir",    32'(dut.r_ir),    32'h0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("idle_req[%0d]", i), 32'(mem_req), 32'h0);
        end

        for (int i = 0; i < 27; i++) begin
            run         = vecs[i].run;
            mem_ack     = vecs[i].ack;
            junk        = vecs[i].junk;
            cnt_wr_en   = vecs[i].cnt;
            literal_adr = vecs[i].lit;
            chk($sformatf("v%0d_req", i),   32'(mem_req),     32'(vecs[i].req));
            chk($sformatf("v%0d_addr", i),  32'(mem_addr),    32'(vecs[i].addr));
            chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].valid));
            chk($sformatf("v%0d_instr", i), 32'(instruction), 32'(vecs[i].instr));
            chk($sformatf("v%0d_pc", i),    32'(pc),          32'(vecs[i].pc));
            step();
        end

        // Reset mid-FETCH at pc=0x12 with the ack still pending.
        run = 1'b1; mem_ack = 1'b0; junk = 1'b0; cnt_wr_en = 1'b0; literal_adr = 8'h00;
        step();
        mem_ack = 1'b1;
        step();
        chk("jmp12_valid", 32'(instr_valid), 32'h1);
        mem_ack = 1'b0; cnt_wr_en = 1'b1; literal_adr = 8'h12;
        step();
        cnt_wr_en = 1'b0; literal_adr = 8'h00;
        chk("pre_rst_req",  32'(mem_req),  32'h1);
        chk("pre_rst_addr", 32'(mem_addr), 32'h12);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_pc",    32'(pc),          32'h0);
        chk("mid_rst_req",   32'(mem_req),     32'h0);
        chk("mid_rst_addr",  32'(mem_addr),    32'h0);
        chk("mid_rst_valid", 32'(instr_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        step();
        mem_ack = 1'b1; junk = 1'b1;
        step();
        mem_ack = 1'b0; junk = 1'b0;
        chk("stray_ack_ir",    32'(dut.r_ir),    32'h0);
        chk("stray_ack_req",   32'(mem_req),     32'h0);
        chk("stray_ack_instr", 32'(instruction), 32'h0);
        chk("stray_ack_pc",    32'(pc),          32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
